// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and default vectors for the program-counter / exception sequencer.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        PCS_SEQ   = 3'b000,
        PCS_BR    = 3'b001,
        PCS_J     = 3'b010,
        PCS_JR    = 3'b011,
        PCS_ILLOP = 3'b100
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

endpackage

// File: rtl/pc_sequencer_irq_sync.sv
// Multi-stage synchroniser bringing the asynchronous interrupt request into the clk domain.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic irq_out
);

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    // Shift chain: stage 0 samples the raw request, each later stage samples its predecessor.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = irq_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign irq_out = sync_q[STAGES-1];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with stall handshake, interrupt/illegal-op traps, EPC capture and flush window.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = DEF_RESET_VEC,
    parameter logic [XLEN-1:0] ILLOP_VEC   = DEF_ILLOP_VEC,
    parameter logic [XLEN-1:0] XADR_VEC    = DEF_XADR_VEC,
    parameter int              IRQ_SYNC    = 2,
    parameter int              FLUSH_DEPTH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic [2:0]      pc_src,
    input  logic            branch_taken,
    input  logic [15:0]     br_offset,
    input  logic [25:0]     jump_index,
    input  logic [XLEN-1:0] jr_target,
    input  logic            irq,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            kernel,
    output logic [XLEN-1:0] epc,
    output logic            epc_we,
    output logic            trap_kill,
    output logic            irq_ack,
    output logic            flush
);

    localparam int              CNT_W      = $clog2(FLUSH_DEPTH + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic             irq_pending_q, irq_pending_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             irq_sync_s;
    logic [XLEN-1:0]  pc_plus4_s;
    logic [XLEN-1:0]  br_target_s;
    logic [XLEN-1:0]  jump_target_s;
    logic [XLEN-1:0]  jr_target_s;
    logic             illop_s;
    logic             adv_s;
    logic             irq_eff_s;
    logic             take_s;
    logic             redirect_s;
    logic             epc_we_s;

    irq_sync #(
        .STAGES (IRQ_SYNC)
    ) u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq),
        .irq_out (irq_sync_s)
    );

    // The kernel bit is carried unchanged; only the low bits wrap.
    assign pc_plus4_s    = {pc_q[XLEN-1], pc_q[XLEN-2:0] + {{(XLEN-4){1'b0}}, 3'd4}};
    assign br_target_s   = pc_plus4_s + {{(XLEN-18){br_offset[15]}}, br_offset, 2'b00};
    assign jump_target_s = {pc_plus4_s[XLEN-1:28], jump_index, 2'b00};
    assign jr_target_s   = pc_q[XLEN-1] ? jr_target : {1'b0, jr_target[XLEN-2:0]};

    assign illop_s   = pc_src[2];
    assign adv_s     = advance & ~reset;
    // The synchroniser output counts as pending in the same cycle so the take lands one edge earlier.
    assign irq_eff_s = irq_pending_q | irq_sync_s;
    assign take_s    = irq_eff_s & ~pc_q[XLEN-1] & adv_s & ~illop_s;

    // Next-PC priority: illegal op, interrupt, explicit redirect, sequential.
    always_comb begin
        pc_d          = pc_q;
        epc_d         = epc_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_s    = 1'b0;
        epc_we_s      = 1'b0;
        irq_pending_d = irq_eff_s & ~take_s;
        if (adv_s) begin
            if (illop_s) begin
                pc_d       = ILLOP_VEC;
                epc_d      = pc_plus4_s;
                epc_we_s   = 1'b1;
                redirect_s = 1'b1;
            end else if (take_s) begin
                pc_d       = XADR_VEC;
                epc_d      = pc_q;
                epc_we_s   = 1'b1;
                redirect_s = 1'b1;
            end else begin
                case (pc_src)
                    PCS_BR: begin
                        if (branch_taken) begin
                            pc_d       = br_target_s;
                            redirect_s = 1'b1;
                        end else begin
                            pc_d = pc_plus4_s;
                        end
                    end
                    PCS_J: begin
                        pc_d       = jump_target_s;
                        redirect_s = 1'b1;
                    end
                    PCS_JR: begin
                        pc_d       = jr_target_s;
                        redirect_s = 1'b1;
                    end
                    default: begin
                        pc_d = pc_plus4_s;
                    end
                endcase
            end
            if (redirect_s) begin
                flush_cnt_d = FLUSH_LOAD;
            end else if (flush_cnt_q != {CNT_W{1'b0}}) begin
                flush_cnt_d = flush_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_d = {CNT_W{1'b0}};
            end
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            epc_q         <= {XLEN{1'b0}};
            irq_pending_q <= 1'b0;
            flush_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            irq_pending_q <= irq_pending_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_s;
    assign kernel    = pc_q[XLEN-1];
    assign epc       = epc_q;
    assign epc_we    = epc_we_s;
    assign trap_kill = take_s;
    assign irq_ack   = take_s;
    assign flush     = (flush_cnt_q != {CNT_W{1'b0}});

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: a behavioural model predicts each edge, two DUTs (flush depth 1 and 3) are compared.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, advance, branch_taken, irq;
    logic [2:0]  pc_src;
    logic [15:0] br_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;

    logic [31:0] pc0, pp40, epc0, pc3, pp43, epc3;
    logic        k0, we0, kill0, ack0, fl0, k3, we3, kill3, ack3, fl3;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk(clk), .reset(reset), .advance(advance), .pc_src(pc_src),
        .branch_taken(branch_taken), .br_offset(br_offset), .jump_index(jump_index),
        .jr_target(jr_target), .irq(irq), .pc(pc0), .pc_plus4(pp40), .kernel(k0),
        .epc(epc0), .epc_we(we0), .trap_kill(kill0), .irq_ack(ack0), .flush(fl0)
    );

    pc_sequencer #(.FLUSH_DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .advance(advance), .pc_src(pc_src),
        .branch_taken(branch_taken), .br_offset(br_offset), .jump_index(jump_index),
        .jr_target(jr_target), .irq(irq), .pc(pc3), .pc_plus4(pp43), .kernel(k3),
        .epc(epc3), .epc_we(we3), .trap_kill(kill3), .irq_ack(ack3), .flush(fl3)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pp4;
        logic [31:0] epc;
        logic        fl1;
        logic        fl3;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_pc, m_epc;
    logic        m_pend, m_s0, m_s1;
    int          m_c1, m_c3;
    logic        l_ack, l_we, l_kill;

    function automatic logic [31:0] z(input logic b);
        return {31'd0, b};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic adv, input logic [2:0] src, input logic bt, input logic [15:0] off,
                        input logic [25:0] idx, input logic [31:0] jrt, input logic irq_v, input logic rst);
        exp_t        e;
        logic [31:0] pp4, npc, nepc;
        logic        eff, take, redir, we;
        @(negedge clk);
        reset = rst; advance = adv; pc_src = src; branch_taken = bt;
        br_offset = off; jump_index = idx; jr_target = jrt; irq = irq_v;
        #1;
        pp4   = {m_pc[31], m_pc[30:0] + 31'd4};
        eff   = m_pend | m_s1;
        take  = eff & ~m_pc[31] & adv & ~src[2] & ~rst;
        npc   = m_pc;
        nepc  = m_epc;
        we    = 1'b0;
        redir = 1'b0;
        if (adv && !rst) begin
            if (src[2]) begin
                npc = DEF_ILLOP_VEC; nepc = pp4; we = 1'b1; redir = 1'b1;
            end else if (take) begin
                npc = DEF_XADR_VEC; nepc = m_pc; we = 1'b1; redir = 1'b1;
            end else if (src == PCS_BR && bt) begin
                npc = pp4 + {{14{off[15]}}, off, 2'b00}; redir = 1'b1;
            end else if (src == PCS_J) begin
                npc = {pp4[31:28], idx, 2'b00}; redir = 1'b1;
            end else if (src == PCS_JR) begin
                npc = m_pc[31] ? jrt : {1'b0, jrt[30:0]}; redir = 1'b1;
            end else begin
                npc = pp4;
            end
        end
        l_ack = ack0; l_we = we0; l_kill = kill0;
        check_eq("epc_we", z(we0), z(we));
        check_eq("irq_ack", z(ack0), z(take));
        check_eq("trap_kill", z(kill0), z(take));
        check_eq("epc_we_d3", z(we3), z(we));
        check_eq("irq_ack_d3", z(ack3), z(take));
        check_eq("trap_kill_d3", z(kill3), z(take));
        if (rst) begin
            m_pc = DEF_RESET_VEC; m_epc = 32'd0; m_pend = 1'b0; m_s0 = 1'b0; m_s1 = 1'b0;
            m_c1 = 0; m_c3 = 0;
        end else begin
            m_pend = eff & ~take;
            m_s1   = m_s0;
            m_s0   = irq_v;
            if (adv) begin
                m_pc  = npc;
                m_epc = nepc;
                m_c1  = redir ? 1 : ((m_c1 > 0) ? m_c1 - 1 : 0);
                m_c3  = redir ? 3 : ((m_c3 > 0) ? m_c3 - 1 : 0);
            end
        end
        e.pc = m_pc; e.pp4 = {m_pc[31], m_pc[30:0] + 31'd4}; e.epc = m_epc;
        e.fl1 = (m_c1 != 0); e.fl3 = (m_c3 != 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("pc", pc0, e.pc);
        check_eq("pc_plus4", pp40, e.pp4);
        check_eq("kernel", z(k0), z(e.pc[31]));
        check_eq("epc", epc0, e.epc);
        check_eq("flush", z(fl0), z(e.fl1));
        check_eq("pc_d3", pc3, e.pc);
        check_eq("pc_plus4_d3", pp43, e.pp4);
        check_eq("kernel_d3", z(k3), z(e.pc[31]));
        check_eq("epc_d3", epc3, e.epc);
        check_eq("flush_d3", z(fl3), z(e.fl3));
    endtask

    task automatic seq();                   step(1'b1, PCS_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0); endtask
    task automatic jr(input logic [31:0] t); step(1'b1, PCS_JR, 1'b0, 16'h0, 26'h0, t, 1'b0, 1'b0); endtask
    task automatic jmp(input logic [25:0] i); step(1'b1, PCS_J, 1'b0, 16'h0, i, 32'h0, 1'b0, 1'b0); endtask
    task automatic br(input logic t, input logic [15:0] o); step(1'b1, PCS_BR, t, o, 26'h0, 32'h0, 1'b0, 1'b0); endtask
    task automatic illop();                 step(1'b1, PCS_ILLOP, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0); endtask
    task automatic stall(input logic i);    step(1'b0, PCS_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, i, 1'b0); endtask
    task automatic rst_cyc();               step(1'b0, PCS_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1); endtask

    initial begin
        reset = 1'b1; advance = 1'b0; pc_src = 3'b000; branch_taken = 1'b0; irq = 1'b0;
        br_offset = 16'h0; jump_index = 26'h0; jr_target = 32'h0;
        m_pc = 32'd0; m_epc = 32'd0; m_pend = 1'b0; m_s0 = 1'b0; m_s1 = 1'b0; m_c1 = 0; m_c3 = 0;

        rst_cyc(); rst_cyc();
        check_eq("rst_pc", pc0, 32'h8000_0000);
        check_eq("rst_epc", epc0, 32'h0);
        check_eq("rst_flush", z(fl0), 32'h0);
        seq();
        check_eq("seq_pc", pc0, 32'h8000_0004);

        jr(32'h7FFF_FFFC);
        seq();
        check_eq("wrap_user", pc0, 32'h0000_0000);
        illop();
        check_eq("illop_pc", pc0, 32'h8000_0004);
        check_eq("illop_epc", epc0, 32'h0000_0004);
        jr(32'hFFFF_FFFC);
        seq();
        check_eq("wrap_kernel", pc0, 32'h8000_0000);

        jr(32'h0000_0100);
        br(1'b1, 16'hFFFE);
        check_eq("br_taken_pc", pc0, 32'h0000_00FC);
        check_eq("br_taken_flush", z(fl0), 32'h1);
        seq();
        check_eq("br_flush_end", z(fl0), 32'h0);
        br(1'b0, 16'hFFFE);
        check_eq("br_nt_pc", pc0, 32'h0000_0104);
        check_eq("br_nt_flush", z(fl0), 32'h0);
        jr(32'h8000_0040);
        check_eq("jr_user_mask", pc0, 32'h0000_0040);

        jr(32'h0000_0200);
        stall(1'b1); stall(1'b0);
        check_eq("irq_wait_pc", pc0, 32'h0000_0200);
        seq();
        check_eq("irq_take_ack", z(l_ack), 32'h1);
        check_eq("irq_take_kill", z(l_kill), 32'h1);
        check_eq("irq_pc", pc0, 32'h8000_0008);
        check_eq("irq_epc", epc0, 32'h0000_0200);

        jr(32'h8000_0010);
        step(1'b1, PCS_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
        seq(); seq(); seq();
        check_eq("masked_pc", pc0, 32'h8000_0020);
        check_eq("masked_ack", z(l_ack), 32'h0);
        jr(32'h0000_0300);
        check_eq("ret_pc", pc0, 32'h0000_0300);
        seq();
        check_eq("late_take_ack", z(l_ack), 32'h1);
        check_eq("late_take_pc", pc0, 32'h8000_0008);
        check_eq("late_take_epc", epc0, 32'h0000_0300);

        jr(32'h0000_0400);
        stall(1'b1); stall(1'b0);
        illop();
        check_eq("prio_ack", z(l_ack), 32'h0);
        check_eq("prio_pc", pc0, 32'h8000_0004);
        check_eq("prio_epc", epc0, 32'h0000_0404);
        jr(32'h0000_0500);
        for (int i = 0; i < 3; i++) begin
            stall(1'b0);
            check_eq("stall_ack", z(l_ack), 32'h0);
            check_eq("stall_pc", pc0, 32'h0000_0500);
        end
        seq();
        check_eq("stall_take_ack", z(l_ack), 32'h1);
        check_eq("stall_take_epc", epc0, 32'h0000_0500);

        jmp(26'h000_0040);
        check_eq("jump_pc", pc0, 32'h8000_0100);
        check_eq("fl3_a", z(fl3), 32'h1);
        jmp(26'h000_0080);
        check_eq("fl3_b", z(fl3), 32'h1);
        seq();
        check_eq("fl3_c", z(fl3), 32'h1);
        check_eq("fl1_c", z(fl0), 32'h0);
        stall(1'b0);
        check_eq("fl3_stall", z(fl3), 32'h1);
        seq();
        check_eq("fl3_d", z(fl3), 32'h1);
        seq();
        check_eq("fl3_e", z(fl3), 32'h0);

        jmp(26'h000_0010);
        rst_cyc();
        check_eq("midflush_pc", pc0, 32'h8000_0000);
        check_eq("midflush_fl3", z(fl3), 32'h0);
        check_eq("midflush_epc", epc0, 32'h0);
        jr(32'h0000_0600);
        step(1'b1, 3'b111, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        check_eq("src111_pc", pc0, 32'h8000_0004);
        check_eq("src111_epc", epc0, 32'h0000_0604);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and exception sequencer for the next-generation MIPS-style core.
- Replaces the flat PC register and next-PC mux with a block that adds:
  - an advance/stall handshake,
  - a synchronised interrupt request with a pending latch,
  - kernel-mode protection on jr,
  - EPC capture,
  - a counted pipeline-flush window.
- Sits between control/decode (pc_src, branch result) and instruction ROM (pc).

Parameters:
- XLEN, 32: address width; bit XLEN-1 is the kernel-mode bit.
- RESET_VEC, 32'h80000000: PC after reset.
- ILLOP_VEC, 32'h80000004: illegal-opcode vector.
- XADR_VEC, 32'h80000008: interrupt vector.
- IRQ_SYNC, 2: irq synchroniser flop count, minimum 1.
- FLUSH_DEPTH, 1: flush cycles after any non-sequential redirect, minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- advance  in  1  1 = PC updates this cycle; 0 = stall, all state holds.
- pc_src  in  3  000 seq, 001 branch, 010 jump, 011 jr, 100 illop; 101-111 treated as illop.
- branch_taken  in  1  ALU compare result, used when pc_src=001.
- br_offset  in  16  branch immediate, in words.
- jump_index  in  26  J-type target field.
- jr_target  in  XLEN  register-file read value for jr/jalr.
- irq  in  1  asynchronous interrupt request, level.
- pc  out  XLEN  current fetch address.
- pc_plus4  out  XLEN  sequential successor, kernel bit preserved.
- kernel  out  1  equals pc[XLEN-1].
- epc  out  XLEN  captured return address.
- epc_we  out  1  one-cycle pulse; datapath writes epc into $26.
- trap_kill  out  1  combinational; suppress RegWrite/MemWrite of the current instruction.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- flush  out  1  high while the flush counter is non-zero.

Behaviour:
- Reset (synchronous, priority over everything else):
  - pc=RESET_VEC; epc=0; irq_pending=0; sync chain=0; flush counter=0.
  - All pulse outputs are 0.
- pc_plus4:
  - low XLEN-1 bits = pc[XLEN-2:0]+4, wrapping modulo 2^(XLEN-1);
  - bit XLEN-1 = pc[XLEN-1].
- Targets:
  - branch = pc_plus4 + (sign-extended br_offset << 2), full XLEN wrap; taken only if branch_taken, otherwise pc_plus4.
  - jump = {pc_plus4[XLEN-1:28], jump_index, 2'b00}.
  - jr = jr_target, except from user mode (kernel=0) bit XLEN-1 is forced to 0.
- irq path:
  - irq passes through IRQ_SYNC flops.
  - irq_pending is set when the synchronised irq is 1.
  - irq_pending is cleared only when the interrupt is taken.
- Interrupt take condition: irq_pending & ~kernel & advance & pc_src not illop.
- Next-PC priority, evaluated only when advance=1:
  1. illop: pc<=ILLOP_VEC; epc<=pc_plus4; epc_we=1.
  2. Interrupt take: pc<=XADR_VEC; epc<=pc; epc_we=1; trap_kill=1; irq_ack=1; irq_pending cleared. The interrupted instruction re-executes on return.
  3. pc_src 001/010/011 as above.
  4. Sequential: pc<=pc_plus4.
- illop pre-empts a simultaneous interrupt; the pending interrupt stays latched and is taken on return to user mode.
- Kernel mode: interrupts are masked; irq_pending keeps accumulating.
- Flush counter:
  - loaded with FLUSH_DEPTH on any advancing cycle whose next PC is not pc_plus4 (taken branch, jump, jr, trap);
  - otherwise decrements toward 0 on advancing cycles;
  - holds on stalls;
  - a new redirect during the flush window reloads the counter;
  - flush = (counter != 0).
- advance=0:
  - pc, epc, counter hold;
  - epc_we, irq_ack, trap_kill are 0;
  - the synchroniser and pending latch still run.
- Latency:
  - irq asserted at edge N can be taken at the earliest on the IRQ_SYNC+1th edge (pending registered), given user mode and advance.
  - Redirects take effect at the next edge.
- Reset mid-flush or mid-stall: everything returns to reset values at the next edge.

Decomposition:
- Shared package:
  - pc_src encoding constants (PCS_SEQ, PCS_BR, PCS_J, PCS_JR, PCS_ILLOP);
  - default vector constants.
- One sub-module: irq_sync, a parametrised IRQ_SYNC-stage synchroniser with reset.
- Next-PC mux, EPC register and flush counter stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles with pc_src=000, then release -> pc=0x80000000, then 0x80000004; flush=0, epc=0.
- Wrap:
  - pc=0x7FFFFFFC, seq -> pc=0x00000000;
  - pc=0xFFFFFFFC, seq -> pc=0x80000000.
- Branch and jr:
  - pc=0x00000100, br_offset=16'hFFFE, taken -> pc=0x000000FC; flush high 1 cycle.
  - Same with branch_taken=0 -> pc=0x00000104; no flush.
  - User-mode jr_target=0x80000040 -> pc=0x00000040.
- Interrupt:
  - User mode pc=0x00000200, irq pulses 1 cycle, IRQ_SYNC=2 -> on the 3rd edge pc=0x80000008, epc=0x00000200; epc_we, irq_ack, trap_kill pulse once.
  - Same irq while pc=0x80000010 -> not taken; taken after jr to 0x00000300.
- Priority and stall:
  - illop with pending irq -> pc=0x80000004, epc=pc+4; irq stays pending.
  - advance=0 for 3 cycles with pending irq -> pc holds, no pulses; taken on the first advancing cycle.
- Flush depth: FLUSH_DEPTH=3, jump then second jump 1 cycle later -> flush high 4 consecutive advancing cycles; stalls during the window extend it.
